// File: rtl/div_arbiter_if.sv
// Requester-side and divider-side buses of the divider arbiter, bundled so the
// arbiter sees the slave view and the environment (requesters + divider) the master view.
interface div_arbiter_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
);
    // Handshake: a request bit i is taken on the rising edge where req_valid_in[i]
    // and req_ready_out[i] are both high; the requester holds valid and operands
    // stable until then. resp_valid_out and div_valid_out are single-cycle strobes
    // with no back-pressure; div_valid_in is a single-cycle result strobe.
    logic [NUM_REQ-1:0]       req_valid_in;
    logic [NUM_REQ*WIDTH-1:0] req_dividend_in;
    logic [NUM_REQ*WIDTH-1:0] req_divisor_in;
    logic [NUM_REQ-1:0]       req_ready_out;
    logic [NUM_REQ-1:0]       resp_valid_out;
    logic [WIDTH-1:0]         resp_quotient_out;
    logic [WIDTH-1:0]         resp_remainder_out;
    logic                     resp_error_out;
    logic [WIDTH-1:0]         div_dividend_out;
    logic [WIDTH-1:0]         div_divisor_out;
    logic                     div_valid_out;
    logic [WIDTH-1:0]         div_quotient_in;
    logic [WIDTH-1:0]         div_remainder_in;
    logic                     div_valid_in;
    logic                     div_busy_in;

    modport slave (
        input  req_valid_in, req_dividend_in, req_divisor_in,
        input  div_quotient_in, div_remainder_in, div_valid_in, div_busy_in,
        output req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out,
        output resp_error_out, div_dividend_out, div_divisor_out, div_valid_out
    );

    modport master (
        output req_valid_in, req_dividend_in, req_divisor_in,
        output div_quotient_in, div_remainder_in, div_valid_in, div_busy_in,
        input  req_ready_out, resp_valid_out, resp_quotient_out, resp_remainder_out,
        input  resp_error_out, div_dividend_out, div_divisor_out, div_valid_out
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one external divider among NUM_REQ requesters,
// one transaction in flight; zero divisors are answered locally without the divider.
module div_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) (
    input  logic         clk_in,
    input  logic         rst_in,
    div_arbiter_if.slave bus,
    output logic         busy_out,
    output logic [1:0]   state_dbg_out
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int CAND_W = IDX_W + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             err_q, err_d;

    logic [CAND_W-1:0] rr_cand;
    logic [IDX_W-1:0]  win_idx;
    logic              win_found;
    logic [WIDTH-1:0]  win_dividend;
    logic [WIDTH-1:0]  win_divisor;
    logic              accept;

    // Scan from farthest to nearest candidate after last_grant so the nearest
    // requesting index is the one left standing.
    always_comb begin
        rr_cand   = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rr_cand = {1'b0, last_grant_q} + CAND_W'(k);
            if (rr_cand >= CAND_W'(NUM_REQ)) begin
                rr_cand = rr_cand - CAND_W'(NUM_REQ);
            end
            if (bus.req_valid_in[rr_cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_cand[IDX_W-1:0];
            end
        end
    end

    assign win_dividend = bus.req_dividend_in[int'(win_idx)*WIDTH +: WIDTH];
    assign win_divisor  = bus.req_divisor_in[int'(win_idx)*WIDTH +: WIDTH];
    assign accept       = (state_q == ST_IDLE) && win_found;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        quot_d       = quot_q;
        rem_d        = rem_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d      = win_idx;
                    last_grant_d = win_idx;
                    dividend_d   = win_dividend;
                    divisor_d    = win_divisor;
                    if (win_divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = win_dividend;
                        err_d   = 1'b1;
                        state_d = ST_RESPOND;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.div_busy_in) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.div_valid_in) begin
                    quot_d  = bus.div_quotient_in;
                    rem_d   = bus.div_remainder_in;
                    err_d   = 1'b0;
                    state_d = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_q      <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            quot_q       <= '0;
            rem_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            quot_q       <= quot_d;
            rem_q        <= rem_d;
            err_q        <= err_d;
        end
    end

    // The start strobe fires in the first ISSUE cycle the divider is free.
    assign bus.div_valid_out      = (state_q == ST_ISSUE) && !bus.div_busy_in;
    assign bus.div_dividend_out   = dividend_q;
    assign bus.div_divisor_out    = divisor_q;
    assign bus.req_ready_out      = accept ? (NUM_REQ'(1) << win_idx) : '0;
    assign bus.resp_valid_out     = (state_q == ST_RESPOND) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.resp_quotient_out  = quot_q;
    assign bus.resp_remainder_out = rem_q;
    assign bus.resp_error_out     = err_q;
    assign busy_out               = (state_q != ST_IDLE);
    assign state_dbg_out          = state_q;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: transaction-level reference model checked every cycle,
// a behavioural divider, directed scenarios and a randomized traffic phase.
module tb_div_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic       clk_in;
    logic       rst_in;
    logic       busy_out;
    logic [1:0] state_dbg;

    div_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) arb_if ();

    div_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (arb_if),
        .busy_out     (busy_out),
        .state_dbg_out(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- requester driver state ----------------
    logic [W-1:0] pend_a [N];
    logic [W-1:0] pend_b [N];
    logic [N-1:0] pend_v;
    logic [N-1:0] refill_en;
    logic [N-1:0] acc_mask;
    bit           rand_post;

    // ---------------- divider model controls ----------------
    int           div_lat;
    bit           busy_force;
    bit           busy_rand;
    bit           stray_en;
    bit           start_seen;
    logic [W-1:0] op_a, op_b;

    // ---------------- observation logs ----------------
    int           resp_count = 0;
    int           dv_count   = 0;
    int           resp_idx_log[$];
    logic [W-1:0] resp_q_log[$];
    logic [W-1:0] resp_r_log[$];
    logic         resp_e_log[$];
    int           resp_cyc_log[$];
    int           last_acc_cyc, last_dv_cyc, last_dvin_cyc;
    logic [W-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            arb_if.req_dividend_in[i*W +: W] = pend_a[i];
            arb_if.req_divisor_in[i*W +: W]  = pend_b[i];
        end
        arb_if.req_valid_in = pend_v;
    endtask

    task automatic post(int i, logic [W-1:0] a, logic [W-1:0] b);
        pend_a[i] = a;
        pend_b[i] = b;
        pend_v[i] = 1'b1;
        drive();
    endtask

    task automatic post_rand(int i);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 100);
        case ($urandom_range(0, 7))
            0:       b = '0;
            1, 2, 3: b = $urandom_range(1, 15);
            default: b = $urandom;
        endcase
        post(i, a, b);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_mask[i]) begin
                if (refill_en[i]) post_rand(i);
                else pend_v[i] = 1'b0;
            end
        end
        if (rand_post) begin
            for (int i = 0; i < N; i++) begin
                if (!pend_v[i] && $urandom_range(0, 3) == 0) post_rand(i);
            end
        end
        drive();
    endtask

    task automatic do_reset();
        pend_v = '0;
        drive();
        rst_in = 1'b1;
        step();
        step();
        rst_in = 1'b0;
    endtask

    task automatic wait_resps(int target, int bound, string name);
        int n;
        n = 0;
        while (resp_count < target && n < bound) begin
            step();
            n++;
        end
        chk(name, resp_count, target);
    endtask

    task automatic check_grant_order(int base, string name);
        int k;
        k = 0;
        while (exp_q.size() > 0) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (base + k < resp_idx_log.size()) chk(name, resp_idx_log[base+k], e);
            else chk(name, 64'hdead, e);
            k++;
        end
    endtask

    // ---------------- behavioural divider ----------------
    bit           dv_pending;
    int           dv_cnt;
    logic [W-1:0] dv_qv, dv_rv;

    initial begin
        arb_if.div_valid_in     = 1'b0;
        arb_if.div_quotient_in  = '0;
        arb_if.div_remainder_in = '0;
        arb_if.div_busy_in      = 1'b0;
        dv_pending = 1'b0;
        dv_cnt     = 0;
        forever begin
            @(posedge clk_in);
            #2;
            arb_if.div_valid_in = 1'b0;
            if (start_seen) begin
                dv_pending = 1'b1;
                dv_cnt     = div_lat;
                dv_qv      = (op_b == '0) ? '1 : op_a / op_b;
                dv_rv      = (op_b == '0) ? op_a : op_a % op_b;
            end
            if (dv_pending) begin
                dv_cnt--;
                if (dv_cnt <= 0) begin
                    arb_if.div_valid_in     = 1'b1;
                    arb_if.div_quotient_in  = dv_qv;
                    arb_if.div_remainder_in = dv_rv;
                    dv_pending = 1'b0;
                end
            end else if (stray_en && $urandom_range(0, 7) == 0) begin
                arb_if.div_valid_in     = 1'b1;
                arb_if.div_quotient_in  = $urandom;
                arb_if.div_remainder_in = $urandom;
            end
            arb_if.div_busy_in = busy_force || (busy_rand && $urandom_range(0, 3) == 0);
        end
    end

    // ---------------- reference model + compare ----------------
    function automatic int rr_pick(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    typedef struct {
        bit           live;
        int           idx;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit           issued;
        bit           answered;
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           err;
    } txn_t;

    txn_t         m;
    int           m_last;
    int           win;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_resp;

    initial begin
        m = '{default: 0};
        m_last = N - 1;
        acc_mask = '0;
        start_seen = 1'b0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                m.live     = 1'b0;
                m_last     = N - 1;
                acc_mask   = '0;
                start_seen = 1'b0;
            end else begin
                win = -1;
                exp_ready = '0;
                if (!m.live) begin
                    win = rr_pick(arb_if.req_valid_in, m_last);
                    if (win >= 0) exp_ready[win] = 1'b1;
                end
                chk("req_ready", arb_if.req_ready_out, exp_ready);
                chk("busy", busy_out, m.live);
                chk("div_valid", arb_if.div_valid_out,
                    m.live && !m.answered && !m.issued && !arb_if.div_busy_in);
                if (m.live && !m.answered) begin
                    chk("div_dividend", arb_if.div_dividend_out, m.a);
                    chk("div_divisor", arb_if.div_divisor_out, m.b);
                end
                exp_resp = '0;
                if (m.live && m.answered) exp_resp[m.idx] = 1'b1;
                chk("resp_valid", arb_if.resp_valid_out, exp_resp);
                if (m.live && m.answered) begin
                    chk("resp_quotient", arb_if.resp_quotient_out, m.q);
                    chk("resp_remainder", arb_if.resp_remainder_out, m.r);
                    chk("resp_error", arb_if.resp_error_out, m.err);
                end

                if (arb_if.resp_valid_out != '0) begin
                    int ridx;
                    ridx = -1;
                    for (int i = 0; i < N; i++) if (arb_if.resp_valid_out[i]) ridx = i;
                    resp_idx_log.push_back(ridx);
                    resp_q_log.push_back(arb_if.resp_quotient_out);
                    resp_r_log.push_back(arb_if.resp_remainder_out);
                    resp_e_log.push_back(arb_if.resp_error_out);
                    resp_cyc_log.push_back(cyc);
                    resp_count++;
                end
                start_seen = arb_if.div_valid_out;
                if (arb_if.div_valid_out) begin
                    op_a = arb_if.div_dividend_out;
                    op_b = arb_if.div_divisor_out;
                    last_dv_cyc = cyc;
                    dv_count++;
                end
                if (arb_if.div_valid_in) last_dvin_cyc = cyc;
                acc_mask = arb_if.req_valid_in & arb_if.req_ready_out;
                if (acc_mask != '0) last_acc_cyc = cyc;

                if (m.live && m.answered) begin
                    m.live = 1'b0;
                end else if (m.live && !m.issued) begin
                    if (!arb_if.div_busy_in) m.issued = 1'b1;
                end else if (m.live) begin
                    if (arb_if.div_valid_in) begin
                        m.answered = 1'b1;
                        m.q   = m.a / m.b;
                        m.r   = m.a % m.b;
                        m.err = 1'b0;
                    end
                end else if (win >= 0) begin
                    m.live     = 1'b1;
                    m.idx      = win;
                    m.a        = arb_if.req_dividend_in[win*W +: W];
                    m.b        = arb_if.req_divisor_in[win*W +: W];
                    m.issued   = 1'b0;
                    m.answered = (m.b == '0);
                    m.q        = '1;
                    m.r        = m.a;
                    m.err      = 1'b1;
                    m_last     = win;
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int dv0;
        int n;
        rst_in     = 1'b1;
        busy_force = 1'b0;
        busy_rand  = 1'b0;
        stray_en   = 1'b0;
        rand_post  = 1'b0;
        refill_en  = '0;
        div_lat    = 1;
        pend_v     = '0;
        for (int i = 0; i < N; i++) begin
            pend_a[i] = '0;
            pend_b[i] = '0;
        end
        drive();
        repeat (3) step();
        rst_in = 1'b0;

        chk("rst_req_ready", arb_if.req_ready_out, 0);
        chk("rst_resp_valid", arb_if.resp_valid_out, 0);
        chk("rst_div_valid", arb_if.div_valid_out, 0);
        chk("rst_resp_error", arb_if.resp_error_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_quotient", arb_if.resp_quotient_out, 0);
        chk("rst_remainder", arb_if.resp_remainder_out, 0);
        chk("rst_div_dividend", arb_if.div_dividend_out, 0);
        chk("rst_div_divisor", arb_if.div_divisor_out, 0);
        step();

        // Requester 1: 100 / 7
        base = resp_count;
        post(1, 100, 7);
        wait_resps(base + 1, 40, "t1_done");
        if (resp_count > base) begin
            chk("t1_idx", resp_idx_log[base], 1);
            chk("t1_quotient", resp_q_log[base], 14);
            chk("t1_remainder", resp_r_log[base], 2);
            chk("t1_error", resp_e_log[base], 0);
            chk("t1_issue_latency", last_dv_cyc - last_acc_cyc, 1);
            chk("t1_resp_latency", resp_cyc_log[base] - last_dvin_cyc, 1);
        end

        // All four requesters valid straight out of reset
        do_reset();
        base = resp_count;
        for (int i = 0; i < N; i++) post_rand(i);
        wait_resps(base + 4, 200, "t2_done");
        for (int i = 0; i < N; i++) exp_q.push_back(W'(i));
        check_grant_order(base, "t2_order");

        // Requester 2: 55 / 0
        base = resp_count;
        dv0  = dv_count;
        post(2, 55, 0);
        wait_resps(base + 1, 20, "t3_done");
        if (resp_count > base) begin
            chk("t3_idx", resp_idx_log[base], 2);
            chk("t3_quotient", resp_q_log[base], 32'hFFFF_FFFF);
            chk("t3_remainder", resp_r_log[base], 55);
            chk("t3_error", resp_e_log[base], 1);
            chk("t3_resp_latency", resp_cyc_log[base] - last_acc_cyc, 1);
            chk("t3_no_divider_start", dv_count, dv0);
        end

        // Divider busy for 5 cycles after accept
        base = resp_count;
        busy_force = 1'b1;
        post(0, 1000, 9);
        n = 0;
        while (pend_v[0] && n < 50) begin
            step();
            n++;
        end
        chk("t4_accept", pend_v[0], 0);
        repeat (5) step();
        busy_force = 1'b0;
        wait_resps(base + 1, 40, "t4_done");
        if (resp_count > base) begin
            chk("t4_issue_delay", last_dv_cyc - last_acc_cyc, 6);
            chk("t4_quotient", resp_q_log[base], 111);
            chk("t4_remainder", resp_r_log[base], 1);
        end

        // Reset while waiting on the divider; its late result must be dropped
        div_lat = 4;
        base = resp_count;
        dv0  = dv_count;
        post(3, 1000, 10);
        n = 0;
        while (dv_count == dv0 && n < 50) begin
            step();
            n++;
        end
        chk("t5_started", dv_count, dv0 + 1);
        chk("t5_busy_in_wait", busy_out, 1);
        step();
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        chk("t5_busy_after_reset", busy_out, 0);
        repeat (6) step();
        chk("t5_no_resp", resp_count, base);
        div_lat = 2;
        post(1, 77, 5);
        wait_resps(base + 1, 40, "t5_next_done");
        if (resp_count > base) begin
            chk("t5_next_idx", resp_idx_log[base], 1);
            chk("t5_next_quotient", resp_q_log[base], 15);
            chk("t5_next_remainder", resp_r_log[base], 2);
        end

        // Requesters 0 and 3 continuously valid
        do_reset();
        base = resp_count;
        refill_en = 4'b1001;
        post_rand(0);
        post_rand(3);
        wait_resps(base + 6, 300, "t6_done");
        refill_en = '0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(W'(0));
            exp_q.push_back(W'(3));
        end
        check_grant_order(base, "t6_alternate");

        // Randomized traffic
        rand_post = 1'b1;
        busy_rand = 1'b1;
        stray_en  = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            div_lat = $urandom_range(1, 5);
            if (c % 200 == 0) refill_en = N'($urandom_range(0, 15));
            step();
        end
        rand_post = 1'b0;
        refill_en = '0;
        busy_rand = 1'b0;
        stray_en  = 1'b0;
        n = 0;
        while ((pend_v != '0 || busy_out) && n < 300) begin
            step();
            n++;
        end
        chk("drain_idle", {pend_v, busy_out}, 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, operand width; NUM_REQ, default 4, number of requesters (2..8).
REQ-002 clk_in  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 req_valid_in  input  NUM_REQ  per-requester request strobe; bit i SHALL be held high until accepted.
REQ-005 req_dividend_in  input  NUM_REQ*WIDTH  flattened dividends; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 req_divisor_in  input  NUM_REQ*WIDTH  flattened divisors, same packing.
REQ-007 req_ready_out  output  NUM_REQ  one-hot accept; the request is taken in the cycle where valid and ready are both high.
REQ-008 resp_valid_out  output  NUM_REQ  one-hot, one-cycle result strobe to the granted requester.
REQ-009 resp_quotient_out / resp_remainder_out  output  WIDTH each  shared result buses, valid only with resp_valid_out.
REQ-010 resp_error_out  output  1  divide-by-zero flag, valid with resp_valid_out.
REQ-011 busy_out  output  1  high whenever state is not IDLE.
REQ-012 div_dividend_out / div_divisor_out  output  WIDTH each  operands to the shared divider.
REQ-013 div_valid_out  output  1  one-cycle start strobe to the divider.
REQ-014 div_quotient_in / div_remainder_in  input  WIDTH each; div_valid_in  input  1; div_busy_in  input  1  divider result and status.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE, WAIT, RESPOND; exactly one transaction in flight.
REQ-016 IDLE: if any req_valid_in bit is high, round-robin SHALL pick the first requesting index after last_grant (wrapping at NUM_REQ-1 to 0).
REQ-017 req_ready_out SHALL be combinational: one-hot winner only in IDLE, zero in all other states.
REQ-018 On acceptance: capture winner index, dividend and divisor; update last_grant to the winner; go to ISSUE if divisor != 0, else RESPOND with the error result.
REQ-019 ISSUE: while div_busy_in is high, stay; when low, drive div_valid_out high for exactly one cycle with captured operands, then go to WAIT.
REQ-020 div_dividend_out/div_divisor_out SHALL hold captured operands from ISSUE through WAIT.
REQ-021 WAIT: on div_valid_in, register div_quotient_in/div_remainder_in, clear error, go to RESPOND; any other cycle stay.
REQ-022 RESPOND: resp_valid_out[grant] high for exactly one cycle with registered results, then go to IDLE; a new request SHALL NOT be accepted in RESPOND.
REQ-023 Divide-by-zero result: quotient all ones, remainder = dividend, resp_error_out = 1; divider SHALL NOT be started.
REQ-024 Latency, accepted at cycle T with idle divider: div_valid_out at T+1; resp_valid_out one cycle after div_valid_in. Zero divisor: resp_valid_out at T+1.
REQ-025 div_valid_in outside WAIT SHALL be ignored.
REQ-026 A requester SHALL be re-granted only after every other continuously requesting index has been served once (no starvation).
REQ-027 Result registers SHALL be WIDTH bits; no truncation or extension.

Reset
REQ-028 While rst_in is high at a clock edge: state IDLE, last_grant = NUM_REQ-1, so requester 0 wins first.
REQ-029 After that edge: req_ready_out is 0 (combinational in IDLE), and resp_valid_out, div_valid_out, resp_error_out, busy_out are 0.
REQ-030 After that edge: resp_quotient_out, resp_remainder_out, div_dividend_out and div_divisor_out are 0.
REQ-031 Reset during any state SHALL abort the transaction; no resp_valid_out for it, and a late div_valid_in SHALL be ignored.

Verification
REQ-032 Requester 1 sends 100/7 with an idle divider -> div_valid_out one cycle after accept; resp_valid_out = 4'b0010, quotient 14, remainder 2, error 0.
REQ-033 All four valid from reset, each held until served -> accept order 0,1,2,3, four resp_valid_out pulses in that order.
REQ-034 Requester 2 sends 55/0 -> no div_valid_out; resp_valid_out = 4'b0100 at T+1, quotient 32'hFFFFFFFF, remainder 55, error 1.
REQ-035 div_busy_in held high 5 cycles after accept -> stay in ISSUE; div_valid_out fires in the first cycle div_busy_in is low.
REQ-036 rst_in pulsed in WAIT, divider returns 2 cycles later -> no resp_valid_out; busy_out 0; next request served normally.
REQ-037 Requesters 0 and 3 held continuously valid -> grants strictly alternate 0,3,0,3.
